// File: rtl/filter_peak_detector_pkg.sv
// Shared types and sizes for the filter peak detector.
package filter_peak_detector_pkg;

  localparam int SIZE_FILTER_DATA = 12;
  localparam int SIZE_TIMESTAMP   = 16;
  localparam int PD_DATA_WIDTH    = SIZE_FILTER_DATA + 4;

  typedef enum logic [1:0] {
    PD_IDLE = 2'd0,
    PD_RISE = 2'd1,
    PD_DEAD = 2'd2
  } pd_state_t;

  // Event record as seen by downstream readout; 'ptime' because 'time' is reserved.
  typedef struct packed {
    logic [PD_DATA_WIDTH-1:0]  amplitude;
    logic [SIZE_TIMESTAMP-1:0] ptime;
    logic                      pileup;
    logic                      timeout;
  } pd_event_t;

endpackage

// File: rtl/filter_peak_detector_baseline_tracker.sv
// Slow baseline follower for the peak detector; present only with PEAK_DETECTOR_BASELINE_EN.
`ifdef PEAK_DETECTOR_BASELINE_EN
module peak_baseline_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int BL_SHIFT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic [DATA_WIDTH-1:0] corrected
);

  // Baseline carries BL_SHIFT fractional bits so small steps are not lost.
  logic [DATA_WIDTH+BL_SHIFT-1:0]        bl;
  logic [DATA_WIDTH-1:0]                 bl_int;
  logic signed [DATA_WIDTH+BL_SHIFT:0]   diff;
  logic signed [DATA_WIDTH+BL_SHIFT:0]   step;

  assign bl_int    = bl[DATA_WIDTH+BL_SHIFT-1:BL_SHIFT];
  assign diff      = $signed({1'b0, input_data, {BL_SHIFT{1'b0}}}) - $signed({1'b0, bl});
  assign step      = diff >>> BL_SHIFT;
  assign corrected = (input_data > bl_int) ? (input_data - bl_int) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bl <= '0;
    end else if (enable) begin
      bl <= bl + step[DATA_WIDTH+BL_SHIFT-1:0];
    end
  end

endmodule
`endif

// File: rtl/filter_peak_detector.sv
// Threshold-crossing pulse detector with peak/timestamp capture, pile-up and timeout flags.
// Optional baseline subtraction is enabled by defining PEAK_DETECTOR_BASELINE_EN.
//
// state   | meaning
// IDLE    | armed, waiting for x > threshold
// RISE    | pulse in progress, tracking maximum and its first timestamp
// DEAD    | post-event dead time, re-arms only on a quiet input
module filter_peak_detector
  import filter_peak_detector_pkg::*;
#(
  parameter int DATA_WIDTH = SIZE_FILTER_DATA + 4,
  parameter int TS_WIDTH   = SIZE_TIMESTAMP,
  parameter int DEAD_TIME  = 8,
  parameter int MAX_LEN    = 64,
  parameter int PILEUP_GAP = 3,
  parameter int CNT_WIDTH  = 16,
  parameter int BL_SHIFT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  peak_valid,
  output logic [DATA_WIDTH-1:0] peak_amplitude,
  output logic [TS_WIDTH-1:0]   peak_time,
  output logic                  peak_pileup,
  output logic                  peak_timeout,
  output logic [CNT_WIDTH-1:0]  event_count,
  output logic                  busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(PILEUP_GAP + 1);
  localparam int DC_W  = $clog2(DEAD_TIME + 1);

  pd_state_t             state;
  logic [TS_WIDTH-1:0]   timestamp;
  logic [TS_WIDTH-1:0]   ptime;
  logic [DATA_WIDTH-1:0] peak;
  logic [LEN_W-1:0]      len;
  logic [GAP_W-1:0]      gap;
  logic [DC_W-1:0]       dead_cnt;
  logic                  pile;

  logic [DATA_WIDTH-1:0] x;
  logic                  above;
  logic                  new_max;
  logic                  pile_next;
  logic                  pulse_end;
  logic [DATA_WIDTH-1:0] peak_next;
  logic [TS_WIDTH-1:0]   ptime_next;

`ifdef PEAK_DETECTOR_BASELINE_EN
  peak_baseline_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .BL_SHIFT   (BL_SHIFT)
  ) u_baseline (
    .clk        (clk),
    .reset      (reset),
    .enable     (state == PD_IDLE),
    .input_data (input_data),
    .corrected  (x)
  );
`else
  logic unused_bl_shift;
  assign unused_bl_shift = ^BL_SHIFT;
  assign x = input_data;
`endif

  // The terminating sample still counts toward the maximum.
  assign above      = x > threshold;
  assign new_max    = x > peak;
  assign peak_next  = new_max ? x : peak;
  assign ptime_next = new_max ? timestamp : ptime;
  assign pile_next  = pile | (new_max && (gap >= GAP_W'(PILEUP_GAP)));
  assign pulse_end  = !above || (len == LEN_W'(MAX_LEN - 1));
  assign busy       = (state != PD_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= PD_IDLE;
      timestamp      <= '0;
      ptime          <= '0;
      peak           <= '0;
      len            <= '0;
      gap            <= '0;
      dead_cnt       <= '0;
      pile           <= 1'b0;
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_pileup    <= 1'b0;
      peak_timeout   <= 1'b0;
      event_count    <= '0;
    end else begin
      timestamp  <= timestamp + TS_WIDTH'(1);
      peak_valid <= 1'b0;
      case (state)
        PD_IDLE: begin
          if (above) begin
            state <= PD_RISE;
            peak  <= x;
            ptime <= timestamp;
            len   <= LEN_W'(1);
            gap   <= '0;
            pile  <= 1'b0;
          end
        end
        PD_RISE: begin
          len   <= len + LEN_W'(1);
          peak  <= peak_next;
          ptime <= ptime_next;
          pile  <= pile_next;
          if (new_max) begin
            gap <= '0;
          end else if (gap != GAP_W'(PILEUP_GAP)) begin
            gap <= gap + GAP_W'(1);
          end
          if (pulse_end) begin
            peak_valid     <= 1'b1;
            peak_amplitude <= peak_next;
            peak_time      <= ptime_next;
            peak_pileup    <= pile_next;
            peak_timeout   <= above;
            if (event_count != '1) begin
              event_count <= event_count + CNT_WIDTH'(1);
            end
            dead_cnt <= DC_W'(DEAD_TIME);
            state    <= PD_DEAD;
          end
        end
        PD_DEAD: begin
          if (dead_cnt > DC_W'(1)) begin
            dead_cnt <= dead_cnt - DC_W'(1);
          end else if (!above) begin
            state <= PD_IDLE;
          end
        end
        default: state <= PD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_peak_detector.sv
// Directed and randomized bench for filter_peak_detector with a pulse-level reference model.
module tb_filter_peak_detector;

  localparam int DW      = 16;
  localparam int TSW     = 16;
  localparam int DT      = 8;
  localparam int ML      = 64;
  localparam int PG      = 3;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] input_data;
  logic [DW-1:0] threshold;
  logic          peak_valid;
  logic [DW-1:0] peak_amplitude;
  logic [TSW-1:0] peak_time;
  logic          peak_pileup;
  logic          peak_timeout;
  logic [CW-1:0] event_count;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int e;
    int amp;
    int tm;
    int pile;
    int to;
  } ev_t;

  int  hx[$];
  int  ht[$];
  ev_t got[$];
  ev_t exp_q[$];

  always #5 clk = ~clk;

  filter_peak_detector #(
    .DATA_WIDTH (DW),
    .TS_WIDTH   (TSW),
    .DEAD_TIME  (DT),
    .MAX_LEN    (ML),
    .PILEUP_GAP (PG),
    .CNT_WIDTH  (CW),
    .BL_SHIFT   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .threshold      (threshold),
    .peak_valid     (peak_valid),
    .peak_amplitude (peak_amplitude),
    .peak_time      (peak_time),
    .peak_pileup    (peak_pileup),
    .peak_timeout   (peak_timeout),
    .event_count    (event_count),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One sample per clock; outputs are captured 1 time unit after the edge.
  task automatic step(input int xv, input int tv);
    ev_t ev;
    input_data = DW'(xv);
    threshold  = DW'(tv);
    @(posedge clk);
    #1;
    hx.push_back(xv);
    ht.push_back(tv);
    if (peak_valid === 1'b1) begin
      ev.e    = hx.size() - 1;
      ev.amp  = int'(peak_amplitude);
      ev.tm   = int'(peak_time);
      ev.pile = int'(peak_pileup);
      ev.to   = int'(peak_timeout);
      got.push_back(ev);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, " valid"},   peak_valid,     0);
    check({tag, " amp"},     peak_amplitude, 0);
    check({tag, " time"},    peak_time,      0);
    check({tag, " pileup"},  peak_pileup,    0);
    check({tag, " timeout"}, peak_timeout,   0);
    check({tag, " count"},   event_count,    0);
    check({tag, " busy"},    busy,           0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hx.delete();
    ht.delete();
    got.delete();
  endtask

  // Reference: walk the sample history pulse by pulse.
  function automatic void scan();
    int i, s, e, amp, mi, pile, to, q, n;
    ev_t ev;
    exp_q.delete();
    n = hx.size();
    i = 0;
    while (i < n) begin
      if (hx[i] <= ht[i]) begin
        i++;
        continue;
      end
      s = i; amp = hx[s]; mi = s; pile = 0; to = 0; e = -1;
      for (int j = s + 1; j < n; j++) begin
        if (hx[j] > amp) begin
          if (j - mi - 1 >= PG) pile = 1;
          amp = hx[j];
          mi  = j;
        end
        if (hx[j] <= ht[j]) begin e = j; break; end
        if (j - s == ML - 1) begin e = j; to = 1; break; end
      end
      if (e < 0) break;
      ev.e = e; ev.amp = amp; ev.tm = mi % (1 << TSW); ev.pile = pile; ev.to = to;
      exp_q.push_back(ev);
      q = e + DT;
      while (q < n && hx[q] > ht[q]) q++;
      i = q + 1;
    end
  endfunction

  task automatic finish_epoch(input string name);
    int m;
    scan();
    check({name, " events"}, got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s ev%0d cycle", name, i),   got[i].e,    exp_q[i].e);
      check($sformatf("%s ev%0d amp", name, i),     got[i].amp,  exp_q[i].amp);
      check($sformatf("%s ev%0d time", name, i),    got[i].tm,   exp_q[i].tm);
      check($sformatf("%s ev%0d pileup", name, i),  got[i].pile, exp_q[i].pile);
      check($sformatf("%s ev%0d timeout", name, i), got[i].to,   exp_q[i].to);
    end
    check({name, " count"}, event_count,
          (exp_q.size() > CNT_MAX) ? CNT_MAX : exp_q.size());
  endtask

  initial begin
    int s;
    int n_before;
    int thr;
    reset      = 1'b1;
    input_data = '0;
    threshold  = DW'(100);

    do_reset("reset");

    // Single pulse: 150 lands at ts=10.
    for (int i = 0; i < 10; i++) step(0, 100);
    step(150, 100);
    check("single busy", busy, 1);
    step(300, 100);
    step(250, 100);
    step(120, 100);
    check("single early valid", peak_valid, 0);
    step(50, 100);
    check("single valid",   peak_valid,     1);
    check("single amp",     peak_amplitude, 300);
    check("single time",    peak_time,      11);
    check("single pileup",  peak_pileup,    0);
    check("single timeout", peak_timeout,   0);
    check("single count",   event_count,    1);

    // Pulse inside dead time must be ignored.
    step(0, 100); step(0, 100);
    step(200, 100); step(250, 100); step(50, 100);
    for (int i = 0; i < 12; i++) step(0, 100);
    check("dead ignored count", event_count, 1);

    // Pile-up: new maximum after a gap of 3 samples.
    step(150, 100); step(400, 100); step(300, 100); step(250, 100);
    step(200, 100); step(500, 100); step(90, 100);
    check("pile valid",  peak_valid,     1);
    check("pile amp",    peak_amplitude, 500);
    check("pile flag",   peak_pileup,    1);
    for (int i = 0; i < 12; i++) step(0, 100);

    // Same shape with gap of 2: no pile-up.
    step(150, 100); step(400, 100); step(300, 100); step(250, 100);
    step(500, 100); step(200, 100); step(90, 100);
    check("nopile valid", peak_valid,     1);
    check("nopile amp",   peak_amplitude, 500);
    check("nopile flag",  peak_pileup,    0);
    for (int i = 0; i < 12; i++) step(0, 100);

    // Timeout with a constant input, then re-arm only on a quiet sample.
    s = hx.size();
    for (int k = 0; k < 80; k++) begin
      step(200, 100);
      if (k == 62) check("timeout early valid", peak_valid, 0);
      if (k == 63) begin
        check("timeout valid", peak_valid,     1);
        check("timeout flag",  peak_timeout,   1);
        check("timeout amp",   peak_amplitude, 200);
        check("timeout time",  peak_time,      s);
        n_before = got.size();
      end
    end
    check("held high no event", got.size(), n_before);
    step(50, 100);
    step(150, 100); step(150, 100); step(150, 100);
    step(50, 100);
    check("rearm valid",   peak_valid,     1);
    check("rearm amp",     peak_amplitude, 150);
    check("rearm timeout", peak_timeout,   0);
    for (int i = 0; i < 12; i++) step(0, 100);

    // Random samples with occasional threshold changes mid-pulse.
    thr = 100;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) thr = $urandom_range(60, 160);
      step($urandom_range(0, 320), thr);
    end
    for (int i = 0; i < 20; i++) step(0, 100);

    // Enough short pulses to saturate the event counter.
    for (int p = 0; p < 16; p++) begin
      step(150, 100);
      step(50, 100);
      for (int i = 0; i < 9; i++) step(0, 100);
    end
    check("count saturated", event_count, CNT_MAX);
    finish_epoch("main");

    // Reset asserted mid-pulse, away from any clock edge.
    do_reset("pre");
    step(0, 100); step(0, 100); step(150, 100); step(300, 100);
    #3;
    do_reset("midrise");
    for (int i = 0; i < 20; i++) step(0, 100);
    check("after reset busy", busy, 0);
    finish_epoch("postreset");

    // Timestamp wrap inside a pulse; maximum lands at ts=1.
    do_reset("wrap");
    for (int i = 0; i < 65533; i++) step(0, 100);
    step(150, 100); step(200, 100); step(250, 100);
    step(400, 100); step(600, 100); step(300, 100); step(50, 100);
    check("wrap valid", peak_valid,     1);
    check("wrap amp",   peak_amplitude, 600);
    check("wrap time",  peak_time,      1);
    finish_epoch("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
